// File: rtl/camac_pkg.sv
// Shared types and constants for the CAMAC dataway master.
// Provides the FSM state enum, function-code classes and station decode.
package camac_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE1,
        ST_GAP,
        ST_STROBE2,
        ST_HOLD,
        ST_RESP
    } state_e;

    // Function classes, decoded from f[4:3]
    localparam logic [1:0] F_READ  = 2'b00;
    localparam logic [1:0] F_WRITE = 2'b10;

    // Named function codes
    localparam logic [4:0] F_RD    = 5'd0;
    localparam logic [4:0] F_CLR   = 5'd9;
    localparam logic [4:0] F_XCHG  = 5'd11;
    localparam logic [4:0] F_WR    = 5'd16;
    localparam logic [4:0] F_ADDR  = 5'd17;
    localparam logic [4:0] F_AMP   = 5'd24;
    localparam logic [4:0] F_AUTO  = 5'd26;
    localparam logic [4:0] F_TESTQ = 5'd27;

    localparam logic [4:0] N_MAX = 5'd23;

    // Station k (1..N_MAX) drives bit k-1; anything else selects nothing.
    function automatic logic [23:0] onehot_n(input logic [4:0] nn);
        logic [23:0] res;
        res = '0;
        if (nn != 5'd0 && nn <= N_MAX) begin
            res = 24'd1 << (nn - 5'd1);
        end
        return res;
    endfunction

endpackage

// File: rtl/camac_dataway_master_timer.sv
// camac_phase_timer: loadable down-counter shared by all dataway phases.
// Ports: clk, rst (async active-low), load/load_val reload, done at zero.
module camac_phase_timer #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == '0);

endmodule

// File: rtl/camac_dataway_master.sv
// CAMAC dataway initiator: runs one N/A/F (or Z) cycle per accepted
// command and returns one response. Ports: cmd_* request handshake,
// rsp_* response pulse, n/a/f/w/b/s1/s2/z dataway drive, r/q/x sampled.
// Build option CAMAC_QRETRY_EN: repeat the cycle while X=1 and Q=0.
module camac_dataway_master
    import camac_pkg::*;
#(
    parameter int T_SETUP   = 10,
    parameter int T_S1      = 10,
    parameter int T_GAP     = 5,
    parameter int T_S2      = 10,
    parameter int T_HOLD    = 5,
    parameter int MAX_RETRY = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_z,
    input  logic [4:0]  cmd_n,
    input  logic [3:0]  cmd_a,
    input  logic [4:0]  cmd_f,
    input  logic [23:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [23:0] rsp_rdata,
    output logic        rsp_q,
    output logic        rsp_x,
    output logic        rsp_err,
    output logic [23:0] n,
    output logic [3:0]  a,
    output logic [4:0]  f,
    output logic [23:0] w,
    output logic        b,
    output logic        s1,
    output logic        s2,
    output logic        z,
    input  logic [23:0] r,
    input  logic        q,
    input  logic        x
);

    localparam int T_M1  = (T_SETUP > T_S1) ? T_SETUP : T_S1;
    localparam int T_M2  = (T_GAP > T_S2) ? T_GAP : T_S2;
    localparam int T_M3  = (T_M1 > T_M2) ? T_M1 : T_M2;
    localparam int T_MAX = (T_M3 > T_HOLD) ? T_M3 : T_HOLD;
    localparam int TW    = $clog2(T_MAX) + 1;

    // Timer is loaded with T-1 so each phase lasts exactly T clocks
    localparam logic [TW-1:0] LD_SETUP = TW'(T_SETUP - 1);
    localparam logic [TW-1:0] LD_S1    = TW'(T_S1 - 1);
    localparam logic [TW-1:0] LD_GAP   = TW'(T_GAP - 1);
    localparam logic [TW-1:0] LD_S2    = TW'(T_S2 - 1);
    localparam logic [TW-1:0] LD_HOLD  = TW'(T_HOLD - 1);

    state_e state_q, state_d;

    logic        cz_q, cz_d;
    logic [4:0]  cn_q, cn_d;
    logic [3:0]  ca_q, ca_d;
    logic [4:0]  cf_q, cf_d;
    logic [23:0] cw_q, cw_d;
    logic        bad_q, bad_d;
    logic        err_q, err_d;
    logic [23:0] cap_r_q, cap_r_d;
    logic        cap_q_q, cap_q_d;
    logic        cap_x_q, cap_x_d;

    logic        cmd_ready_q, cmd_ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [23:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_q_q, rsp_q_d;
    logic        rsp_x_q, rsp_x_d;
    logic        rsp_err_q, rsp_err_d;
    logic [23:0] n_q, n_d;
    logic [3:0]  a_q, a_d;
    logic [4:0]  f_q, f_d;
    logic [23:0] w_q, w_d;
    logic        b_q, b_d;
    logic        s1_q, s1_d;
    logic        s2_q, s2_d;
    logic        z_q, z_d;

    logic          tmr_load;
    logic [TW-1:0] tmr_val;
    logic          tmr_done;
    logic          act;
    logic          naf;

`ifdef CAMAC_QRETRY_EN
    localparam int RW = $clog2(MAX_RETRY + 1);
    logic [RW-1:0] retry_q, retry_d;
`endif

    camac_phase_timer #(
        .W(TW)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (tmr_load),
        .load_val(tmr_val),
        .done    (tmr_done)
    );

    always_comb begin
        state_d  = state_q;
        cz_d     = cz_q;
        cn_d     = cn_q;
        ca_d     = ca_q;
        cf_d     = cf_q;
        cw_d     = cw_q;
        bad_d    = bad_q;
        err_d    = err_q;
        cap_r_d  = cap_r_q;
        cap_q_d  = cap_q_q;
        cap_x_d  = cap_x_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
`ifdef CAMAC_QRETRY_EN
        retry_d  = retry_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
`ifdef CAMAC_QRETRY_EN
                retry_d = '0;
`endif
                if (cmd_valid) begin
                    cz_d     = cmd_z;
                    cn_d     = cmd_n;
                    ca_d     = cmd_a;
                    cf_d     = cmd_f;
                    cw_d     = cmd_wdata;
                    bad_d    = !cmd_z && (cmd_n == 5'd0 || cmd_n > N_MAX);
                    err_d    = bad_d;
                    cap_r_d  = '0;
                    cap_q_d  = 1'b0;
                    cap_x_d  = 1'b0;
                    state_d  = ST_SETUP;
                    tmr_load = 1'b1;
                    tmr_val  = LD_SETUP;
                end
            end
            ST_SETUP: begin
                // Illegal station: skip the dataway cycle entirely
                if (bad_q) begin
                    state_d = ST_RESP;
                end else if (tmr_done) begin
                    state_d  = ST_STROBE1;
                    tmr_load = 1'b1;
                    tmr_val  = LD_S1;
                end
            end
            ST_STROBE1: begin
                if (tmr_done) begin
                    state_d  = ST_GAP;
                    tmr_load = 1'b1;
                    tmr_val  = LD_GAP;
                    // Sample the bus on the edge that drops S1
                    if (!cz_q) begin
                        cap_q_d = q;
                        cap_x_d = x;
                        cap_r_d = (cf_q[4:3] == F_READ) ? r : '0;
                    end
                end
            end
            ST_GAP: begin
                if (tmr_done) begin
                    state_d  = ST_STROBE2;
                    tmr_load = 1'b1;
                    tmr_val  = LD_S2;
                end
            end
            ST_STROBE2: begin
                if (tmr_done) begin
                    state_d  = ST_HOLD;
                    tmr_load = 1'b1;
                    tmr_val  = LD_HOLD;
                end
            end
            ST_HOLD: begin
                if (tmr_done) begin
                    state_d = ST_RESP;
`ifdef CAMAC_QRETRY_EN
                    if (!cz_q && cap_x_q && !cap_q_q) begin
                        retry_d = retry_q + RW'(1);
                        if (retry_d == RW'(MAX_RETRY)) begin
                            err_d = 1'b1;
                        end else begin
                            state_d  = ST_SETUP;
                            tmr_load = 1'b1;
                            tmr_val  = LD_SETUP;
                        end
                    end
`endif
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they are flop outputs
        act  = (state_d inside {ST_SETUP, ST_STROBE1, ST_GAP,
                                ST_STROBE2, ST_HOLD}) && !bad_d;
        naf  = act && !cz_d;
        b_d  = act;
        z_d  = act && cz_d;
        n_d  = naf ? onehot_n(cn_d) : '0;
        a_d  = naf ? ca_d : '0;
        f_d  = naf ? cf_d : '0;
        w_d  = (naf && cf_d[4:3] == F_WRITE) ? cw_d : '0;
        s1_d = (state_d == ST_STROBE1) && naf;
        s2_d = (state_d == ST_STROBE2) && act;

        cmd_ready_d = (state_d == ST_IDLE);
        rsp_valid_d = (state_d == ST_RESP);
        rsp_rdata_d = rsp_rdata_q;
        rsp_q_d     = rsp_q_q;
        rsp_x_d     = rsp_x_q;
        rsp_err_d   = rsp_err_q;
        if (state_d == ST_RESP) begin
            rsp_rdata_d = cap_r_d;
            rsp_q_d     = cap_q_d && !err_d;
            rsp_x_d     = cap_x_d;
            rsp_err_d   = err_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cz_q        <= 1'b0;
            cn_q        <= '0;
            ca_q        <= '0;
            cf_q        <= '0;
            cw_q        <= '0;
            bad_q       <= 1'b0;
            err_q       <= 1'b0;
            cap_r_q     <= '0;
            cap_q_q     <= 1'b0;
            cap_x_q     <= 1'b0;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_q_q     <= 1'b0;
            rsp_x_q     <= 1'b0;
            rsp_err_q   <= 1'b0;
            n_q         <= '0;
            a_q         <= '0;
            f_q         <= '0;
            w_q         <= '0;
            b_q         <= 1'b0;
            s1_q        <= 1'b0;
            s2_q        <= 1'b0;
            z_q         <= 1'b0;
`ifdef CAMAC_QRETRY_EN
            retry_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cz_q        <= cz_d;
            cn_q        <= cn_d;
            ca_q        <= ca_d;
            cf_q        <= cf_d;
            cw_q        <= cw_d;
            bad_q       <= bad_d;
            err_q       <= err_d;
            cap_r_q     <= cap_r_d;
            cap_q_q     <= cap_q_d;
            cap_x_q     <= cap_x_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_q_q     <= rsp_q_d;
            rsp_x_q     <= rsp_x_d;
            rsp_err_q   <= rsp_err_d;
            n_q         <= n_d;
            a_q         <= a_d;
            f_q         <= f_d;
            w_q         <= w_d;
            b_q         <= b_d;
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            z_q         <= z_d;
`ifdef CAMAC_QRETRY_EN
            retry_q     <= retry_d;
`endif
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_q     = rsp_q_q;
    assign rsp_x     = rsp_x_q;
    assign rsp_err   = rsp_err_q;
    assign n         = n_q;
    assign a         = a_q;
    assign f         = f_q;
    assign w         = w_q;
    assign b         = b_q;
    assign s1        = s1_q;
    assign s2        = s2_q;
    assign z         = z_q;

endmodule

// File: tb/tb_camac_dataway_master.sv
// Scoreboard bench for camac_dataway_master (default build).
// Directed NAF/Z/illegal-N/reset vectors; monitor checks every response.
module tb_camac_dataway_master;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_z;
    logic [4:0]  cmd_n;
    logic [3:0]  cmd_a;
    logic [4:0]  cmd_f;
    logic [23:0] cmd_wdata;
    logic        rsp_valid;
    logic [23:0] rsp_rdata;
    logic        rsp_q;
    logic        rsp_x;
    logic        rsp_err;
    logic [23:0] n;
    logic [3:0]  a;
    logic [4:0]  f;
    logic [23:0] w;
    logic        b;
    logic        s1;
    logic        s2;
    logic        z;
    logic [23:0] r;
    logic        q;
    logic        x;

    camac_dataway_master dut (
        .clk      (clk),
        .rst      (rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_z    (cmd_z),
        .cmd_n    (cmd_n),
        .cmd_a    (cmd_a),
        .cmd_f    (cmd_f),
        .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .rsp_q    (rsp_q),
        .rsp_x    (rsp_x),
        .rsp_err  (rsp_err),
        .n        (n),
        .a        (a),
        .f        (f),
        .w        (w),
        .b        (b),
        .s1       (s1),
        .s2       (s2),
        .z        (z),
        .r        (r),
        .q        (q),
        .x        (x)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] rdata;
        logic        q;
        logic        x;
        logic        err;
        int          lat;
    } exp_t;

    exp_t sb[$];

    int pass_cnt = 0;
    int total_cnt = 0;
    int rsp_seen = 0;
    int cyc = 0;
    int acc_cyc = 0;

    // Expected dataway drive while b is high
    logic [23:0] exp_n, exp_w;
    logic [3:0]  exp_a;
    logic [4:0]  exp_f;
    int b_hi, s1_hi, s1_rise, s2_hi, s2_rise, z_hi;
    int bus_bad, w_bad, idle_bad;
    logic s1_prev = 1'b0;
    logic s2_prev = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        total_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, req);
    endtask

    always @(posedge clk) begin
        if (rst && cmd_valid && cmd_ready) acc_cyc <= cyc;
        cyc <= cyc + 1;
    end

    // Response monitor
    always @(negedge clk) begin
        exp_t e;
        if (rst && rsp_valid) begin
            if (sb.size() == 0) begin
                total_cnt++;
                $display("FAIL unexpected_rsp: got rsp_valid=1 expected none");
            end else begin
                e = sb.pop_front();
                chk("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
                chk("rsp_q", 32'(rsp_q), 32'(e.q));
                chk("rsp_x", 32'(rsp_x), 32'(e.x));
                chk("rsp_err", 32'(rsp_err), 32'(e.err));
                chk("latency", 32'(cyc - acc_cyc), 32'(e.lat));
                chk("ready_low_in_resp", 32'(cmd_ready), 32'd0);
                rsp_seen++;
            end
        end
    end

    // Dataway monitor
    always @(negedge clk) begin
        if (b) begin
            b_hi++;
            if (n !== exp_n || a !== exp_a || f !== exp_f) bus_bad++;
            if (w !== exp_w) w_bad++;
        end else if (n != 0 || w != 0 || a != 0 || f != 0 || z || s1 || s2) begin
            idle_bad++;
        end
        if (s1) s1_hi++;
        if (s1 && !s1_prev) s1_rise++;
        if (s2) s2_hi++;
        if (s2 && !s2_prev) s2_rise++;
        if (z) z_hi++;
        s1_prev = s1;
        s2_prev = s2;
    end

    task automatic clr_mon();
        b_hi = 0; s1_hi = 0; s1_rise = 0; s2_hi = 0; s2_rise = 0;
        z_hi = 0; bus_bad = 0; w_bad = 0; idle_bad = 0;
    endtask

    task automatic issue(input logic zz, input logic [4:0] nn,
                         input logic [3:0] aa, input logic [4:0] ff,
                         input logic [23:0] wd);
        int k;
        k = 0;
        @(negedge clk);
        while (!cmd_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (!cmd_ready) begin
            total_cnt++;
            $display("FAIL ready_timeout: got cmd_ready=0 expected 1");
        end
        cmd_z = zz; cmd_n = nn; cmd_a = aa; cmd_f = ff; cmd_wdata = wd;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic run_cmd(
        input string nm,
        input logic zz, input logic [4:0] nn, input logic [3:0] aa,
        input logic [4:0] ff, input logic [23:0] wd,
        input logic [23:0] rr, input logic qq, input logic xx,
        input logic [23:0] e_rd, input logic e_q, input logic e_x,
        input logic e_err, input int e_lat,
        input logic [23:0] e_n, input logic [23:0] e_w,
        input int e_b, input int e_s1, input int e_s2, input int e_z);
        exp_t e;
        int n0;
        @(posedge clk);
        #1;
        r = rr; q = qq; x = xx;
        exp_n = e_n; exp_w = e_w;
        exp_a = zz ? 4'd0 : aa;
        exp_f = zz ? 5'd0 : ff;
        clr_mon();
        e.rdata = e_rd; e.q = e_q; e.x = e_x; e.err = e_err; e.lat = e_lat;
        sb.push_back(e);
        n0 = rsp_seen;
        issue(zz, nn, aa, ff, wd);
        for (int i = 0; i < 200 && rsp_seen == n0; i++) @(negedge clk);
        if (rsp_seen == n0) begin
            total_cnt++;
            $display("FAIL %s rsp_timeout: got no response expected one", nm);
        end
        repeat (4) @(posedge clk);
        #1;
        chk({nm, ".b_clocks"}, 32'(b_hi), 32'(e_b));
        chk({nm, ".s1_clocks"}, 32'(s1_hi), 32'(e_s1));
        chk({nm, ".s1_pulses"}, 32'(s1_rise), (e_s1 > 0) ? 32'd1 : 32'd0);
        chk({nm, ".s2_clocks"}, 32'(s2_hi), 32'(e_s2));
        chk({nm, ".s2_pulses"}, 32'(s2_rise), (e_s2 > 0) ? 32'd1 : 32'd0);
        chk({nm, ".z_clocks"}, 32'(z_hi), 32'(e_z));
        chk({nm, ".naf_bad"}, 32'(bus_bad), 32'd0);
        chk({nm, ".w_bad"}, 32'(w_bad), 32'd0);
        chk({nm, ".idle_bad"}, 32'(idle_bad), 32'd0);
        chk({nm, ".ready_after"}, 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        int k;
        rst = 1'b0;
        cmd_valid = 1'b0; cmd_z = 1'b0; cmd_n = '0; cmd_a = '0;
        cmd_f = '0; cmd_wdata = '0;
        r = '0; q = 1'b0; x = 1'b0;
        exp_n = '0; exp_w = '0; exp_a = '0; exp_f = '0;
        clr_mon();
        #13;
        chk("rst.cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst.rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst.b", 32'(b), 32'd0);
        chk("rst.n", 32'(n), 32'd0);
        chk("rst.s1s2z", {29'd0, s1, s2, z}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        run_cmd("f0_read", 0, 5'd5, 4'd2, 5'd0, 24'h0,
                24'hABCDEF, 1, 1, 24'hABCDEF, 1, 1, 0, 41,
                24'h000010, 24'h0, 40, 10, 10, 0);
        chk("hold.rsp_rdata", 32'(rsp_rdata), 32'h00ABCDEF);
        chk("hold.rsp_q", 32'(rsp_q), 32'd1);
        chk("hold.rsp_valid", 32'(rsp_valid), 32'd0);

        run_cmd("f16_write", 0, 5'd1, 4'd0, 5'd16, 24'h0000AA,
                24'hFFFFFF, 1, 1, 24'h0, 1, 1, 0, 41,
                24'h000001, 24'h0000AA, 40, 10, 10, 0);

        run_cmd("z_cycle", 1, 5'd9, 4'd3, 5'd5, 24'h00FFFF,
                24'h777777, 1, 1, 24'h0, 0, 0, 0, 41,
                24'h0, 24'h0, 40, 0, 10, 40);

        run_cmd("n0_illegal", 0, 5'd0, 4'd1, 5'd0, 24'h0,
                24'h111111, 1, 1, 24'h0, 0, 0, 1, 2,
                24'h0, 24'h0, 0, 0, 0, 0);

        run_cmd("n24_illegal", 0, 5'd24, 4'd1, 5'd16, 24'h123,
                24'h111111, 1, 1, 24'h0, 0, 0, 1, 2,
                24'h0, 24'h0, 0, 0, 0, 0);

        run_cmd("empty_station", 0, 5'd7, 4'd0, 5'd0, 24'h0,
                24'h0, 0, 0, 24'h0, 0, 0, 0, 41,
                24'h000040, 24'h0, 40, 10, 10, 0);

        run_cmd("f9_n23", 0, 5'd23, 4'd15, 5'd9, 24'hAAAAAA,
                24'h555555, 1, 1, 24'h0, 1, 1, 0, 41,
                24'h400000, 24'h0, 40, 10, 10, 0);

        run_cmd("f17_noq", 0, 5'd12, 4'd4, 5'd17, 24'h123456,
                24'h654321, 0, 1, 24'h0, 0, 1, 0, 41,
                24'h000800, 24'h123456, 40, 10, 10, 0);

        // Reset in the middle of S1: no response may follow
        @(posedge clk);
        #1;
        r = 24'h00BEEF; q = 1'b1; x = 1'b1;
        issue(0, 5'd3, 4'd0, 5'd0, 24'h0);
        k = 0;
        while (!s1 && k < 60) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("abort.s1_reached", 32'(s1), 32'd1);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("abort.s1", 32'(s1), 32'd0);
        chk("abort.b", 32'(b), 32'd0);
        chk("abort.n", 32'(n), 32'd0);
        chk("abort.ready", 32'(cmd_ready), 32'd1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (60) @(negedge clk);
        chk("abort.ready_after", 32'(cmd_ready), 32'd1);

        run_cmd("after_abort", 0, 5'd2, 4'd1, 5'd0, 24'h0,
                24'h00F00D, 1, 1, 24'h00F00D, 1, 1, 0, 41,
                24'h000002, 24'h0, 40, 10, 10, 0);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/camac_dataway_master.md
Name: camac_dataway_master

Overview:
- Dataway initiator (crate-controller side) for the Messbauer CAMAC accumulator and other modules on the same dataway.
- Accepts single NAF commands from the host/control logic through a valid/ready handshake.
- Runs one standard CAMAC cycle per command: N/A/F/B setup, S1 strobe, gap, S2 strobe, hold.
- Samples R, Q and X at the end of S1 and returns one response per command.

Parameters:
- T_SETUP, 10, clocks N/A/F/W held stable before S1 (>=1)
- T_S1, 10, S1 high width in clocks (>=1)
- T_GAP, 5, clocks between S1 fall and S2 rise (>=1)
- T_S2, 10, S2 high width in clocks (>=1)
- T_HOLD, 5, clocks N/A/F/W/B held after S2 fall (>=1)
- MAX_RETRY, 7, Q-retry limit (used only with the optional feature)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-low
- cmd_valid  in  1  command request
- cmd_ready  out  1  master idle, command accepted when valid&ready
- cmd_z  in  1  1 = dataway Initialise cycle (Z) instead of NAF
- cmd_n  in  5  station number, 1..23
- cmd_a  in  4  subaddress
- cmd_f  in  5  function code
- cmd_wdata  in  24  write data for F16..F23
- rsp_valid  out  1  one-clock response pulse
- rsp_rdata  out  24  R lines latched at S1 fall; 0 for non-read functions
- rsp_q  out  1  Q latched at S1 fall
- rsp_x  out  1  X latched at S1 fall; 0 = no module response
- rsp_err  out  1  illegal N (0 or >23), or retry exhausted
- n  out  24  one-hot station select, bit k = station k+1
- a  out  4  dataway A
- f  out  5  dataway F
- w  out  24  dataway W write lines
- b  out  1  dataway Busy
- s1  out  1  strobe 1
- s2  out  1  strobe 2
- z  out  1  Initialise
- r  in  24  dataway read lines
- q  in  1  module Q response
- x  in  1  module X response

Behaviour:
- Reset (rst=0, asynchronous): every output 0, except cmd_ready=1. FSM goes to IDLE and all timers clear.
- FSM states: IDLE -> SETUP -> STROBE1 -> GAP -> STROBE2 -> HOLD -> RESP -> IDLE.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid, latch every cmd_* field, drop cmd_ready and enter SETUP.
  - If cmd_z=0 and N is 0 or >23, go straight to RESP with rsp_err=1, rsp_x=0, rsp_q=0, rsp_rdata=0. No dataway activity.
- SETUP (T_SETUP clocks): b=1.
  - NAF cycle: n=one-hot(N), a, f driven.
  - w=cmd_wdata only when f[4:3]==2'b10 (F16..F23), otherwise w=0.
  - Z cycle: n=0, a=0, f=0, z=1.
- STROBE1 (T_S1 clocks): s1=1, but only on NAF cycles; a Z cycle keeps s1=0. On the last clock of STROBE1, latch q, x, and r (r only when f[4:3]==2'b00).
- GAP (T_GAP clocks): s1=0.
- STROBE2 (T_S2 clocks): s2=1 on all cycles, including Z.
- HOLD (T_HOLD clocks): s2=0. On exit, n/a/f/w/b/z return to 0.
- RESP: rsp_valid=1 for exactly one clock with the latched values, then IDLE.
  - rsp_* hold their values until the next RESP.
  - cmd_ready rises in the same clock RESP ends.
- Cycle latency, acceptance to rsp_valid: T_SETUP+T_S1+T_GAP+T_S2+T_HOLD+1 clocks (41 with defaults).
- Timing: every output is registered, so dataway lines change only on clk edges and s1/s2 are glitch-free.
- Counters: a single phase timer, width clog2(max T_*)+1, reloaded at each state entry.
- Z cycle response: rsp_x=0, rsp_q=0, rsp_rdata=0.
- cmd_valid while busy is ignored (not queued). The host holds it until cmd_ready.
- Reset mid-cycle aborts the cycle immediately: all strobes and b drop asynchronously, and no response is produced.

Optional Feature:
- Macro: CAMAC_QRETRY_EN.
- Defined:
  - On a NAF cycle with x=1 and q=0, RESP is skipped. HOLD returns to SETUP with the same NAF and increments a retry counter.
  - When the counter reaches MAX_RETRY, respond with rsp_q=0 and rsp_err=1.
  - The counter clears in IDLE.
  - Only q=1, or x=0, ends the retries early with a normal response.
- Undefined: no retry. One cycle per command; retry counter and logic absent.

Decomposition:
- Package camac_pkg:
  - FSM state enum.
  - Function-class constants: F_READ (f[4:3]=00), F_WRITE (10), plus named codes F_RD=0, F_CLR=9, F_WR=16, F_ADDR=17, F_AMP=24, F_AUTO=26, F_TESTQ=27, F_XCHG=11.
  - N_MAX=23.
  - Function onehot_n().
- Sub-module: camac_phase_timer, a loadable down-counter with a done flag, used for all phases.

Test Plan:
- F0 read, N=5, A=2, r=24'hABCDEF, q=1, x=1 -> n=24'h000010 throughout b; one s1 pulse of 10 clk and one s2 pulse of 10 clk; rsp_rdata=24'hABCDEF, rsp_q=1, rsp_x=1, rsp_valid 41 clk after acceptance.
- F16 write, N=1, cmd_wdata=24'h0000AA -> w=24'h0000AA from SETUP through HOLD; rsp_rdata=0; w=0 after HOLD.
- Z cycle -> z=1, s1 never asserted, s2 pulses once, n=0; rsp_x=0.
- N=0 and N=24 -> no b/s1/s2 activity; rsp_err=1 two clocks after acceptance.
- x=0 (empty station) -> rsp_x=0, rsp_q=0. With CAMAC_QRETRY_EN and q held 0, x=1 -> 7 full cycles, then rsp_err=1.
- rst low during STROBE1 -> s1, b, n drop the same clock; no rsp_valid; cmd_ready=1 after release; next command completes normally.
